// File: rtl/dmem_responder.sv
// Doubleword data memory with fixed response latency, address checking and
// a one-cycle MemReady strobe; AddrError qualifies MemReady for rejected requests.
module dmem_responder #(
   parameter int DEPTH   = 32,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [63:0] Address,
   input  logic [63:0] WriteData,
   output logic [63:0] ReadData,
   output logic        MemReady,
   output logic        Busy,
   output logic        AddrError
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = $clog2(LATENCY + 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [IW-1:0] idx_q;
   logic [63:0]   wdata_q;
   logic          wr_q;
   logic          err_q;
   logic [63:0]   mem [DEPTH];

   logic req;
   logic addr_ok;
   logic req_err;
   logic commit;

   // Validity is decided at acceptance so only the index needs to be held.
   assign req     = MemRead | MemWrite;
   assign addr_ok = (Address[2:0] == 3'b000) && (Address[63:3+IW] == '0);
   assign req_err = (MemRead & MemWrite) | ~addr_ok;
   assign commit  = (state == ACCESS) && (cnt == '0) && !err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  state   <= ACCESS;
                  cnt     <= CW'(LATENCY - 1);
                  idx_q   <= Address[3 +: IW];
                  wdata_q <= WriteData;
                  wr_q    <= MemWrite;
                  err_q   <= req_err;
               end
            end
            ACCESS: begin
               if (cnt == '0) state <= DONE;
               else           cnt   <= cnt - CW'(1);
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[IW'(i)] <= '0;
      end else if (commit && wr_q) begin
         mem[idx_q] <= wdata_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)                ReadData <= '0;
      else if (commit && !wr_q) ReadData <= mem[idx_q];
   end

   assign MemReady  = (state == DONE);
   assign Busy      = (state != IDLE);
   assign AddrError = MemReady & err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus pushes expected responses,
// a negedge monitor pops and compares on every MemReady strobe.
module tb_dmem_responder;

   localparam int DEPTH   = 32;
   localparam int LATENCY = 2;

   logic        clk;
   logic        reset;
   logic        MemRead;
   logic        MemWrite;
   logic [63:0] Address;
   logic [63:0] WriteData;
   logic [63:0] ReadData;
   logic        MemReady;
   logic        Busy;
   logic        AddrError;

   typedef struct packed {
      logic [63:0] rd;
      logic        err;
   } resp_t;

   resp_t       exp_q[$];
   resp_t       mon_e;
   logic [63:0] mem_m [DEPTH];
   logic [63:0] rd_m;
   int          vectors     = 0;
   int          miscompares = 0;

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
      .clk       (clk),
      .reset     (reset),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .Address   (Address),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .MemReady  (MemReady),
      .Busy      (Busy),
      .AddrError (AddrError)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, expected bench completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic void model_clear();
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      rd_m = '0;
   endfunction

   function automatic void expect_req(input logic rd, input logic wr,
                                      input logic [63:0] addr, input logic [63:0] data);
      logic       ok;
      logic [4:0] idx;
      ok  = (addr[2:0] == 3'b000) && (addr[63:8] == 56'h0);
      idx = addr[7:3];
      if ((rd && wr) || !ok) begin
         exp_q.push_back('{rd_m, 1'b1});
      end else begin
         if (wr) mem_m[idx] = data;
         else    rd_m       = mem_m[idx];
         exp_q.push_back('{rd_m, 1'b0});
      end
   endfunction

   always @(negedge clk) begin
      if (MemReady === 1'b1) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL spurious_ready: MemReady=1 with no outstanding request, expected 0");
         end else begin
            mon_e = exp_q.pop_front();
            chk("resp_readdata", ReadData, mon_e.rd);
            chk("resp_addrerror", {63'b0, AddrError}, {63'b0, mon_e.err});
         end
      end else begin
         chk("addrerror_without_ready", {63'b0, AddrError}, 64'd0);
      end
   end

   task automatic wait_idle();
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (!Busy) return;
      end
      vectors++;
      miscompares++;
      $display("FAIL busy_timeout: Busy=%b after 20 cycles, expected 0", Busy);
   endtask

   // Called #1 after an edge with the DUT idle.
   task automatic issue(input logic rd, input logic wr,
                        input logic [63:0] addr, input logic [63:0] data);
      MemRead   = rd;
      MemWrite  = wr;
      Address   = addr;
      WriteData = data;
      expect_req(rd, wr, addr, data);
      @(posedge clk); #1;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      wait_idle();
   endtask

   initial begin
      reset     = 1'b1;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      Address   = '0;
      WriteData = '0;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_readdata", ReadData, 64'd0);
      chk("reset_ready", {63'b0, MemReady}, 64'd0);
      chk("reset_busy", {63'b0, Busy}, 64'd0);
      chk("reset_addrerror", {63'b0, AddrError}, 64'd0);
      reset = 1'b0;

      // Write with edge-by-edge timing checks
      MemWrite  = 1'b1;
      Address   = 64'h10;
      WriteData = 64'hDEADBEEFCAFEF00D;
      expect_req(1'b0, 1'b1, 64'h10, 64'hDEADBEEFCAFEF00D);
      @(posedge clk); #1;
      MemWrite = 1'b0;
      chk("e0_busy", {63'b0, Busy}, 64'd1);
      chk("e0_ready", {63'b0, MemReady}, 64'd0);
      @(posedge clk); #1;
      chk("e1_busy", {63'b0, Busy}, 64'd1);
      chk("e1_ready", {63'b0, MemReady}, 64'd0);
      @(posedge clk); #1;
      chk("e2_ready", {63'b0, MemReady}, 64'd1);
      chk("e2_busy", {63'b0, Busy}, 64'd1);
      @(posedge clk); #1;
      chk("e3_busy", {63'b0, Busy}, 64'd0);
      chk("e3_ready", {63'b0, MemReady}, 64'd0);

      issue(1'b1, 1'b0, 64'h10, 64'd0);
      @(posedge clk); #1;
      chk("hold_readdata", ReadData, 64'hDEADBEEFCAFEF00D);

      // Rejected requests leave ReadData and the array untouched
      issue(1'b1, 1'b0, 64'h13, 64'd0);
      issue(1'b1, 1'b0, 64'h100, 64'd0);
      issue(1'b0, 1'b1, 64'h100, 64'h5555);
      issue(1'b0, 1'b1, 64'h8000000000000008, 64'h77);
      issue(1'b1, 1'b0, 64'h0, 64'd0);
      issue(1'b1, 1'b1, 64'h8, 64'h1111);
      issue(1'b1, 1'b0, 64'h8, 64'd0);

      // Boundary indices and write-then-read
      issue(1'b0, 1'b1, 64'h38, 64'hA5A5A5A55A5A5A5A);
      issue(1'b0, 1'b1, 64'hF8, 64'h0123456789ABCDEF);
      issue(1'b1, 1'b0, 64'hF8, 64'd0);
      issue(1'b1, 1'b0, 64'h38, 64'd0);
      issue(1'b1, 1'b0, 64'h10, 64'd0);

      // Reset aborts an in-flight write; requests ignored while reset is high
      MemWrite  = 1'b1;
      Address   = 64'h18;
      WriteData = 64'h1234;
      @(posedge clk); #1;
      MemWrite = 1'b0;
      reset    = 1'b1;
      @(posedge clk); #1;
      model_clear();
      chk("abort_ready", {63'b0, MemReady}, 64'd0);
      chk("abort_busy", {63'b0, Busy}, 64'd0);
      chk("abort_addrerror", {63'b0, AddrError}, 64'd0);
      chk("abort_readdata", ReadData, 64'd0);
      MemRead = 1'b1;
      Address = 64'h18;
      expect_req(1'b1, 1'b0, 64'h18, 64'd0);
      @(posedge clk); #1;
      chk("req_during_reset_busy", {63'b0, Busy}, 64'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      MemRead = 1'b0;
      chk("first_accept_busy", {63'b0, Busy}, 64'd1);
      wait_idle();
      issue(1'b1, 1'b0, 64'h10, 64'd0);

      // Write held high across a prior read is taken exactly once
      issue(1'b0, 1'b1, 64'h38, 64'h0F0F0F0F0F0F0F0F);
      MemRead = 1'b1;
      Address = 64'h38;
      expect_req(1'b1, 1'b0, 64'h38, 64'd0);
      @(posedge clk); #1;
      MemRead   = 1'b0;
      MemWrite  = 1'b1;
      Address   = 64'h20;
      WriteData = 64'hFEEDFACE00C0FFEE;
      expect_req(1'b0, 1'b1, 64'h20, 64'hFEEDFACE00C0FFEE);
      wait_idle();
      @(posedge clk); #1;
      chk("held_write_accept", {63'b0, Busy}, 64'd1);
      MemWrite = 1'b0;
      wait_idle();
      issue(1'b1, 1'b0, 64'h20, 64'd0);

      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
